// File: rtl/instruction_memory_pkg.sv
// instruction_memory_pkg
//   Constants and types shared by the instruction memory and its byte loader.
//   - Default geometry: IMEM_DEPTH words of 32 bits, addressed by IMEM_ADDR_W bits.
//   - NOP: the instruction word the fetch register is forced to during load mode.
//   - ld_state_e: loader FSM state encoding.
package instruction_memory_pkg;

    localparam int IMEM_DEPTH  = 256;
    localparam int IMEM_ADDR_W = 8;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_FULL    = 2'd2
    } ld_state_e;

endpackage

// File: rtl/imem_byte_loader.sv
// imem_byte_loader
//   Byte-serial loader. It assembles little-endian 32-bit words from a byte
//   stream and emits one memory write per completed word, at sequential
//   addresses starting from 0.
//   Ports:
//     clk, reset (async, active-low)
//     write_en            load mode; its rising edge starts a new load
//     byte_in, byte_valid loader data stream
//     wr_en, wr_addr, wr_data  write strobe to the memory array (same edge)
//     word_count          words written since the last load start
//     load_busy           a partial word (1-3 bytes) is pending
//     mem_full, overflow  capacity reached / byte received while full (sticky)
module imem_byte_loader
    import instruction_memory_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              load_busy,
    output logic              mem_full,
    output logic              overflow
);

    // word_count value just before the final word is written
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       asm_q, asm_d;      // bytes 0..2 of the word in progress
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              we_q;              // write_en delayed, for edge detect

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            ptr_q   <= '0;
            wc_q    <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            we_q    <= write_en;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        ptr_d   = ptr_q;
        wc_d    = wc_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        // the 4th byte goes straight to memory, it never lands in asm_q
        wr_data = {byte_in, asm_q};

        if (!write_en) begin
            // leaving load mode drops any partial word; counts are kept
            state_d = LD_IDLE;
            cnt_d   = '0;
        end else if (!we_q) begin
            // load start; a byte on this same edge is byte 0 of the new load
            state_d = LD_COLLECT;
            cnt_d   = '0;
            ptr_d   = '0;
            wc_d    = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
            if (byte_valid) begin
                asm_d[7:0] = byte_in;
                cnt_d      = 2'd1;
            end
        end else begin
            case (state_q)
                LD_COLLECT: begin
                    if (byte_valid) begin
                        if (cnt_q == 2'd3) begin
                            wr_en = 1'b1;
                            cnt_d = '0;
                            ptr_d = ptr_q + 1'b1;
                            wc_d  = wc_q + 1'b1;
                            if (wc_q == LAST_CNT) begin
                                full_d  = 1'b1;
                                state_d = LD_FULL;
                            end
                        end else begin
                            case (cnt_q)
                                2'd0:    asm_d[7:0]   = byte_in;
                                2'd1:    asm_d[15:8]  = byte_in;
                                default: asm_d[23:16] = byte_in;
                            endcase
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LD_FULL: begin
                    if (byte_valid) ovf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign word_count = wc_q;
    assign load_busy  = (cnt_q != 2'd0);
    assign mem_full   = full_q;
    assign overflow   = ovf_q;

endmodule

// File: rtl/instruction_memory.sv
// instruction_memory
//   Word-addressed instruction memory for the IF stage. It returns mem[pc]
//   one cycle after the PC is presented, under the same clk_en/stall control
//   as the PC. In load mode (write_en) fetch is disabled, the output is forced
//   to NOP, and the byte loader fills the array from address 0.
//   Ports:
//     clk, reset (async, active-low)
//     clk_en, stall       fetch enable / hazard hold (stall wins)
//     write_en            load mode
//     pc                  byte address; only pc[ADDR_W+1:2] is used
//     byte_in, byte_valid loader stream
//     instruction         registered fetch result
//     word_count, load_busy, mem_full, overflow  loader status
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            stall,
    input  logic            write_en,
    input  logic [31:0]     pc,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic [31:0]     instruction,
    output logic [ADDR_W:0] word_count,
    output logic            load_busy,
    output logic            mem_full,
    output logic            overflow
);

    logic [31:0]       mem [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] rd_idx;
    logic              unused_pc_bits;

    // upper bits drop out so fetch addresses wrap modulo DEPTH
    assign rd_idx         = pc[ADDR_W+1:2];
    assign unused_pc_bits = ^{pc[31:ADDR_W+2], pc[1:0]};

    imem_byte_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .word_count (word_count),
        .load_busy  (load_busy),
        .mem_full   (mem_full),
        .overflow   (overflow)
    );

    // contents survive reset; only the loader writes them
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instruction <= NOP;
        else if (write_en)
            instruction <= NOP;
        else if (clk_en && !stall)
            instruction <= mem[rd_idx];
    end

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            clk_en;
    logic            stall;
    logic            write_en;
    logic [31:0]     pc;
    logic [7:0]      byte_in;
    logic            byte_valid;
    logic [31:0]     instruction;
    logic [ADDR_W:0] word_count;
    logic            load_busy;
    logic            mem_full;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    instruction_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .stall       (stall),
        .write_en    (write_en),
        .pc          (pc),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .instruction (instruction),
        .word_count  (word_count),
        .load_busy   (load_busy),
        .mem_full    (mem_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // stimulus drivers (no checking inside)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic start_load();
        write_en = 1'b1;
        tick();
    endtask

    task automatic end_load();
        write_en = 1'b0;
        tick();
    endtask

    task automatic fetch(input logic [31:0] a);
        pc     = a;
        clk_en = 1'b1;
        stall  = 1'b0;
        tick();
        clk_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction, 32'h0); end
        checks++; if (word_count !== 3'd0) begin failures++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
        checks++; if ({load_busy, mem_full, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {load_busy, mem_full, overflow}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        start_load();
        send_byte(8'h20);
        send_byte(8'h08);
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL single_busy_mid got=%b exp=1", load_busy); end
        send_byte(8'h00);
        send_byte(8'h05);
        checks++; if (word_count !== 3'd1) begin failures++; $display("FAIL single_wc got=%0d exp=1", word_count); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", load_busy); end
        end_load();
        fetch(32'd0);
        checks++; if (instruction !== 32'h0500_0820) begin failures++; $display("FAIL single_fetch got=%h exp=%h", instruction, 32'h0500_0820); end
    endtask

    task automatic test_stall();
        start_load();
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        for (int i = 0; i < 4; i++) send_byte(8'h22);
        end_load();
        checks++; if (word_count !== 3'd2) begin failures++; $display("FAIL stall_wc got=%0d exp=2", word_count); end
        fetch(32'd0);
        checks++; if (instruction !== 32'h1111_1111) begin failures++; $display("FAIL stall_fetch0 got=%h exp=%h", instruction, 32'h1111_1111); end
        pc     = 32'd4;
        clk_en = 1'b1;
        stall  = 1'b1;
        tick();
        checks++; if (instruction !== 32'h1111_1111) begin failures++; $display("FAIL stall_hold got=%h exp=%h", instruction, 32'h1111_1111); end
        stall = 1'b0;
        tick();
        clk_en = 1'b0;
        checks++; if (instruction !== 32'h2222_2222) begin failures++; $display("FAIL stall_release got=%h exp=%h", instruction, 32'h2222_2222); end
    endtask

    task automatic test_partial();
        start_load();
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL partial_nop got=%h exp=0", instruction); end
        send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
        send_byte(8'h01); send_byte(8'h02);
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL partial_busy got=%b exp=1", load_busy); end
        end_load();
        checks++; if (word_count !== 3'd1) begin failures++; $display("FAIL partial_wc got=%0d exp=1", word_count); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL partial_busy_end got=%b exp=0", load_busy); end
        fetch(32'd4);
        checks++; if (instruction !== 32'h2222_2222) begin failures++; $display("FAIL partial_mem1 got=%h exp=%h", instruction, 32'h2222_2222); end
        fetch(32'd0);
        checks++; if (instruction !== 32'hAABB_CCDD) begin failures++; $display("FAIL partial_mem0 got=%h exp=%h", instruction, 32'hAABB_CCDD); end
    endtask

    task automatic test_fill();
        start_load();
        checks++; if (word_count !== 3'd0) begin failures++; $display("FAIL fill_wc_start got=%0d exp=0", word_count); end
        for (int i = 0; i < 12; i++) send_byte(8'h10 + 8'(i));
        checks++; if ({mem_full, word_count} !== {1'b0, 3'd3}) begin failures++; $display("FAIL fill_3words got=%b/%0d exp=0/3", mem_full, word_count); end
        for (int i = 12; i < 16; i++) send_byte(8'h10 + 8'(i));
        checks++; if (mem_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", mem_full); end
        checks++; if (word_count !== 3'd4) begin failures++; $display("FAIL fill_wc got=%0d exp=4", word_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_pre got=%b exp=0", overflow); end
        send_byte(8'hEE);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL fill_busy got=%b exp=0", load_busy); end
        end_load();
        checks++; if ({mem_full, overflow, word_count} !== {1'b1, 1'b1, 3'd4}) begin failures++; $display("FAIL fill_idle_hold got=%b%b/%0d exp=11/4", mem_full, overflow, word_count); end
        fetch(32'd0);
        checks++; if (instruction !== 32'h1312_1110) begin failures++; $display("FAIL fill_mem0 got=%h exp=%h", instruction, 32'h1312_1110); end
        fetch(32'd12);
        checks++; if (instruction !== 32'h1F1E_1D1C) begin failures++; $display("FAIL fill_mem3 got=%h exp=%h", instruction, 32'h1F1E_1D1C); end
    endtask

    task automatic test_wrap();
        fetch(32'd4 * DEPTH + 32'd8);
        checks++; if (instruction !== 32'h1B1A_1918) begin failures++; $display("FAIL wrap_fetch got=%h exp=%h", instruction, 32'h1B1A_1918); end
        clk_en = 1'b0;
        pc     = 32'd0;
        tick();
        pc     = 32'd4;
        tick();
        checks++; if (instruction !== 32'h1B1A_1918) begin failures++; $display("FAIL wrap_hold got=%h exp=%h", instruction, 32'h1B1A_1918); end
        send_byte(8'h99);   // outside load mode: must be ignored
        checks++; if ({word_count, overflow, load_busy} !== {3'd4, 1'b1, 1'b0}) begin failures++; $display("FAIL idle_byte got=%0d/%b%b exp=4/10", word_count, overflow, load_busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({instruction, word_count, mem_full, overflow} !== {32'h0, 3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL async_reset got=%h/%0d/%b%b exp=0/0/00", instruction, word_count, mem_full, overflow); end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_midload();
        start_load();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hA1); send_byte(8'hA2);
        checks++; if ({word_count, load_busy} !== {3'd1, 1'b1}) begin failures++; $display("FAIL midload_pre got=%0d/%b exp=1/1", word_count, load_busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({instruction, word_count, load_busy, mem_full, overflow} !== {32'h0, 3'd0, 3'b000}) begin failures++; $display("FAIL midload_reset got=%h/%0d/%b%b%b exp=0/0/000", instruction, word_count, load_busy, mem_full, overflow); end
        write_en = 1'b0;
        #2 reset = 1'b1;
        tick();
        // load start and first byte on the same edge
        write_en   = 1'b1;
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", load_busy); end
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        checks++; if ({word_count, load_busy} !== {3'd1, 1'b0}) begin failures++; $display("FAIL restart_wc got=%0d/%b exp=1/0", word_count, load_busy); end
        end_load();
        fetch(32'd0);
        checks++; if (instruction !== 32'h8877_6655) begin failures++; $display("FAIL restart_mem0 got=%h exp=%h", instruction, 32'h8877_6655); end
        fetch(32'd4);
        checks++; if (instruction !== 32'h1716_1514) begin failures++; $display("FAIL restart_mem1 got=%h exp=%h", instruction, 32'h1716_1514); end
    endtask

    initial begin
        reset      = 1'b0;
        clk_en     = 1'b0;
        stall      = 1'b0;
        write_en   = 1'b0;
        pc         = 32'd0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_single_word();
        test_stall();
        test_partial();
        test_fill();
        test_wrap();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
